// File: rtl/ff_bank.sv
// ff_bank: WIDTH-bit register bank whose bits all act as SR, JK, D or T
// flip-flops, chosen by a run-time mode. Illegal SR=11 resolves to a fixed
// value set by a parameter and is also captured in a sticky per-bit error
// flag. A saturating counter records how many updating edges changed q.

module ff_bank #(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}},
    parameter int               SR_ILLEGAL = 0,
    parameter int               CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] err,
    output logic             err_any,
    output logic [CNT_W-1:0] chg_cnt
);

    // Mode encodings, shared by every bit of the bank.
    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    // Out-of-range SR_ILLEGAL values fall back to "hold".
    localparam int SR_ILL_EFF = ((SR_ILLEGAL == 32'sd1) || (SR_ILLEGAL == 32'sd2))
                                ? SR_ILLEGAL : 32'sd0;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] err_r;
    logic [CNT_W-1:0] cnt_r;

    logic [WIDTH-1:0] next_q_s;
    logic [WIDTH-1:0] err_set_s;
    logic [WIDTH-1:0] err_next_s;
    logic             changed_s;
    logic [CNT_W-1:0] cnt_next_s;

    // Resolution of SR=11 for one bit, given its current value.
    function automatic logic sr_illegal_bit(input logic qv);
        logic rv;
        case (SR_ILL_EFF)
            32'sd1:  rv = 1'b0;
            32'sd2:  rv = 1'b1;
            default: rv = qv;
        endcase
        return rv;
    endfunction

    // Next state of a single flip-flop bit for an enabled edge.
    function automatic logic next_bit(input logic [1:0] m,
                                      input logic       qv,
                                      input logic       av,
                                      input logic       bv);
        logic nv;
        nv = qv;
        case (m)
            MODE_SR: begin
                case ({av, bv})
                    2'b00:   nv = qv;
                    2'b01:   nv = 1'b0;
                    2'b10:   nv = 1'b1;
                    2'b11:   nv = sr_illegal_bit(qv);
                    default: nv = qv;
                endcase
            end
            MODE_JK: begin
                case ({av, bv})
                    2'b00:   nv = qv;
                    2'b01:   nv = 1'b0;
                    2'b10:   nv = 1'b1;
                    2'b11:   nv = ~qv;
                    default: nv = qv;
                endcase
            end
            MODE_D: begin
                nv = av;
            end
            MODE_T: begin
                if (av) begin
                    nv = ~qv;
                end else begin
                    nv = qv;
                end
            end
            default: nv = qv;
        endcase
        return nv;
    endfunction

    // Per-bit next q; a disabled edge leaves every bit untouched.
    always_comb begin
        next_q_s = q_r;
        for (int i = 0; i < WIDTH; i++) begin
            if (en) begin
                next_q_s[i] = next_bit(mode, q_r[i], a[i], b[i]);
            end else begin
                next_q_s[i] = q_r[i];
            end
        end
    end

    // Bits that see SR=11 on an enabled edge raise their error flag.
    always_comb begin
        err_set_s = {WIDTH{1'b0}};
        if (en && (mode == MODE_SR)) begin
            err_set_s = a & b;
        end else begin
            err_set_s = {WIDTH{1'b0}};
        end
    end

    // Sticky error update; a fresh set survives a simultaneous clear.
    always_comb begin
        err_next_s = err_r;
        if (clr) begin
            err_next_s = err_set_s;
        end else begin
            err_next_s = err_r | err_set_s;
        end
    end

    // Change detection and saturating counter update, with clear taking
    // priority but still counting a change on the clearing edge.
    always_comb begin
        changed_s  = |(next_q_s ^ q_r);
        cnt_next_s = cnt_r;
        if (clr) begin
            if (changed_s) begin
                cnt_next_s = CNT_ONE;
            end else begin
                cnt_next_s = CNT_ZERO;
            end
        end else if (changed_s && (cnt_r != CNT_MAX)) begin
            cnt_next_s = cnt_r + CNT_ONE;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Flip-flop state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= RESET_VAL;
        end else begin
            q_r <= next_q_s;
        end
    end

    // Sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= {WIDTH{1'b0}};
        end else begin
            err_r <= err_next_s;
        end
    end

    // Change counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    assign q       = q_r;
    assign qb      = ~q_r;
    assign err     = err_r;
    assign err_any = |err_r;
    assign chg_cnt = cnt_r;

    ff_bank_chk #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .q       (q_r),
        .qb      (qb),
        .err     (err_r),
        .err_any (err_any),
        .chg_cnt (cnt_r)
    );

endmodule

// ff_bank_chk: structural invariants of the bank outputs.
module ff_bank_chk #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input logic             clk,
    input logic             rst_n,
    input logic             clr,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] qb,
    input logic [WIDTH-1:0] err,
    input logic             err_any,
    input logic [CNT_W-1:0] chg_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // qb is always the exact complement of q.
    a_qb_inv: assert property (@(posedge clk) disable iff (!rst_n) qb == ~q);

    // err_any mirrors the OR of the error flags.
    a_err_any: assert property (@(posedge clk) disable iff (!rst_n) err_any == (|err));

    // Without a clear, a saturated counter stays saturated.
    a_cnt_sat: assert property (@(posedge clk) disable iff (!rst_n)
        (!clr && (chg_cnt == CNT_MAX)) |=> (chg_cnt == CNT_MAX));

    // Without a clear, no error flag ever drops.
    a_err_sticky: assert property (@(posedge clk) disable iff (!rst_n)
        (!clr) |=> ((err & $past(err)) == $past(err)));

endmodule

// File: doc/ff_bank.md
Name: ff_bank

Overview:
- Parametrised successor to the team's single-bit SR flip-flop: a WIDTH-bit register bank where every bit behaves as an SR, JK, D or T flip-flop, selected at run time.
- Adds the following, none of which the single-bit SR flip-flop has:
  - defined handling of the illegal SR=11 input (no Z output);
  - sticky per-bit error capture;
  - asynchronous reset;
  - clock enable;
  - a saturating change counter.
- Used as a generic state/flag register in lab datapaths and as a reference model for flip-flop characterisation benches.

Parameters:
- WIDTH, 4: number of flip-flop bits in the bank.
- RESET_VAL, 0: value of q after reset; WIDTH bits.
- SR_ILLEGAL, 0: q result for SR mode with a=b=1. 0 = hold, 1 = reset-dominant (q=0), 2 = set-dominant (q=1).
- CNT_W, 8: width of the change counter.

Ports:
- clk  input  1  rising-edge clock for all state
- rst_n  input  1  asynchronous active-low reset
- en  input  1  clock enable for q updates
- mode  input  2  00=SR, 01=JK, 10=D, 11=T; applies to all bits
- a  input  WIDTH  S / J / D / T input per bit
- b  input  WIDTH  R / K input per bit; ignored in D and T modes
- clr  input  1  synchronous clear of err and chg_cnt
- q  output  WIDTH  flip-flop state
- qb  output  WIDTH  always ~q
- err  output  WIDTH  sticky per-bit illegal-SR flag
- err_any  output  1  OR-reduction of err
- chg_cnt  output  CNT_W  number of updating edges where q changed, saturating

Behaviour:
- Reset (rst_n=0), asynchronous, effective immediately regardless of clk:
  - q=RESET_VAL, qb=~RESET_VAL;
  - err=0, err_any=0;
  - chg_cnt=0.
- Reset release is synchronous to the next rising clk; first update on the first edge with rst_n=1.
- All outputs are registered or derived from registers; q updates on the same edge its inputs are sampled (latency 1 edge). qb and err_any are combinational from q and err. No X or Z is ever driven.
- en=0: q holds and chg_cnt does not increment. clr still acts.
- Per-bit next state, for en=1, with a[i], b[i]:
  - SR: 00 hold, 01 -> 0, 10 -> 1, 11 -> per SR_ILLEGAL.
  - JK: 00 hold, 01 -> 0, 10 -> 1, 11 -> toggle.
  - D: q = a[i].
  - T: a[i]=1 toggles, a[i]=0 holds.
- Mode may change on any cycle; the value sampled at each edge governs that edge only. No state is held per mode.
- err[i] is set on an edge with en=1, mode=SR, a[i]=b[i]=1. It stays set until clr or reset.
- clr=1 at an edge:
  - err is cleared, except bits being set on the same edge, which end at 1 (set wins);
  - chg_cnt is cleared; if q changes on the same edge, chg_cnt=1.
- chg_cnt increments by 1 on any edge where en=1 and next q != current q (any bit). It saturates at 2^CNT_W-1 and does not wrap.
- Reset mid-operation: all state returns to reset values at once, including err and the counter.
- SR_ILLEGAL values outside 0..2 are treated as 0.
- Parameter ranges: WIDTH >= 1, CNT_W >= 1.

Test Plan:
- Reset and SR (WIDTH=4): hold rst_n=0 -> q=0000, qb=1111, err=0, chg_cnt=0. Release, mode=00, a=0101, b=0000, en=1 -> q=0101, chg_cnt=1. Then a=0000, b=0001 -> q=0100, chg_cnt=2.
- Illegal SR (SR_ILLEGAL=0): q=0100, a=b=1100 -> q=0100 (hold), err=1100, err_any=1, chg_cnt unchanged. Next cycle with legal inputs -> err stays 1100. Repeat with SR_ILLEGAL=1: q becomes 0000. With SR_ILLEGAL=2: q becomes 1100.
- JK and T toggle: q=0101, mode=01, a=b=1111 -> q=1010; a=b=0000 -> q=1010 (hold). mode=11, a=0011 -> q=1001. err never sets in these modes.
- D mode and enable gating: mode=10, a=1111, en=0 for 3 edges -> q unchanged, chg_cnt unchanged. en=1 -> q=1111 on that edge, chg_cnt +1. Same a again -> no change, no increment.
- clr collisions: err=1100, clr=1 while mode=00 with a=b=0001 -> err=0001. clr=1 on an edge where q changes -> chg_cnt=1.
- Saturation and async reset: CNT_W=2, toggle T mode with a=0001 for 5 edges -> chg_cnt 1,2,3,3,3. Assert rst_n low between clock edges -> q=RESET_VAL and chg_cnt=0 immediately, before the next edge.
